// File: rtl/hourly_chime_ctrl.sv
// Hourly chime sequencer: steps alarm_hourly_en through 1..2N at half-second
// phases at the top of each hour (or on test request), driving the buzzer on odd steps.
module hourly_chime_ctrl #(
  parameter int unsigned HALF_SEC_CYCLES = 16_500_000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic       PixelClk,
  input  logic       nRST,
  input  logic       chime_on,
  input  logic [5:0] hour_decimal,
  input  logic [5:0] minute_decimal,
  input  logic [5:0] second_decimal,
  input  logic       test_req,
  input  logic       cancel,
  output logic [5:0] alarm_hourly_en,
  output logic       buzzer,
  output logic       busy
);

  typedef enum logic {
    IDLE,
    CHIME
  } state_e;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(HALF_SEC_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [5:0]       step_q, step_d;
  logic [4:0]       n_q, n_d;
  logic             top_q, top_d;
  logic             manual_q, manual_d;
  logic             buzzer_q, buzzer_d;
  logic             auto_start, man_start;

  always_ff @(posedge PixelClk) begin
    if (!nRST) begin
      state_q  <= IDLE;
      div_q    <= '0;
      step_q   <= '0;
      n_q      <= '0;
      top_q    <= 1'b0;
      manual_q <= 1'b0;
      buzzer_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      step_q   <= step_d;
      n_q      <= n_d;
      top_q    <= top_d;
      manual_q <= manual_d;
      buzzer_q <= buzzer_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    step_d   = step_q;
    n_d      = n_q;
    manual_d = manual_q;

    top_d      = chime_on && (minute_decimal == 6'd0) && (second_decimal == 6'd0)
                 && (hour_decimal != 6'd0);
    auto_start = top_d && !top_q;
    man_start  = test_req && (hour_decimal != 6'd0);

    unique case (state_q)
      IDLE: begin
        // Cancel beats any start; a coincident auto start marks the run as auto.
        if (!cancel && (auto_start || man_start)) begin
          state_d  = CHIME;
          n_d      = hour_decimal[4:0];
          step_d   = 6'd1;
          div_d    = '0;
          manual_d = !auto_start;
        end
      end
      CHIME: begin
        if (cancel || (!chime_on && !manual_q)) begin
          state_d = IDLE;
          step_d  = '0;
          div_d   = '0;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          if (step_q == {n_q, 1'b0}) begin
            state_d = IDLE;
            step_d  = '0;
          end else begin
            step_d = step_q + 6'd1;
          end
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    buzzer_d = (state_d == CHIME) && step_d[0];
  end

  assign alarm_hourly_en = step_q;
  assign buzzer          = buzzer_q;
  assign busy            = (state_q == CHIME);

endmodule

// File: tb/tb_hourly_chime_ctrl.sv
// Self-checking bench for hourly_chime_ctrl: directed scenarios plus random
// traffic, compared against an elapsed-time reference model.
module tb_hourly_chime_ctrl;

  localparam int H = 4;

  logic       PixelClk = 1'b0;
  logic       nRST = 1'b0;
  logic       chime_on = 1'b0;
  logic [5:0] hour_decimal = '0;
  logic [5:0] minute_decimal = 6'd1;
  logic [5:0] second_decimal = '0;
  logic       test_req = 1'b0;
  logic       cancel = 1'b0;
  logic [5:0] alarm_hourly_en;
  logic       buzzer;
  logic       busy;

  int checks = 0;
  int errors = 0;

  hourly_chime_ctrl #(.HALF_SEC_CYCLES(H), .CNT_W(3)) dut (
    .PixelClk       (PixelClk),
    .nRST           (nRST),
    .chime_on       (chime_on),
    .hour_decimal   (hour_decimal),
    .minute_decimal (minute_decimal),
    .second_decimal (second_decimal),
    .test_req       (test_req),
    .cancel         (cancel),
    .alarm_hourly_en(alarm_hourly_en),
    .buzzer         (buzzer),
    .busy           (busy)
  );

  always #5 PixelClk = ~PixelClk;

  // Reference: a run is a start time plus elapsed cycles; step = 1 + elapsed/H.
  bit m_active = 0, m_manual = 0, m_prev_top = 0, m_top, m_rise;
  int m_elapsed = 0, m_n = 0;

  always @(posedge PixelClk) begin
    m_top = chime_on && minute_decimal == 0 && second_decimal == 0 && hour_decimal != 0;
    if (!nRST) begin
      m_active = 0; m_manual = 0; m_prev_top = 0;
    end else begin
      m_rise = m_top && !m_prev_top;
      m_prev_top = m_top;
      if (m_active) begin
        if (cancel || (!chime_on && !m_manual)) m_active = 0;
        else begin
          m_elapsed++;
          if (m_elapsed == 2 * m_n * H) m_active = 0;
        end
      end else if (!cancel && (m_rise || (test_req && hour_decimal != 0))) begin
        m_active = 1; m_elapsed = 0; m_n = hour_decimal; m_manual = !m_rise;
      end
    end
  end

  function automatic logic [7:0] m_out();
    logic [5:0] e;
    e = m_active ? 6'(1 + m_elapsed / H) : 6'd0;
    return {e, m_active & e[0], m_active};
  endfunction

  task automatic tick();
    @(posedge PixelClk);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    tick(); tick();
    checks++;
    if ({alarm_hourly_en, buzzer, busy} !== 8'h00) begin
      errors++;
      $display("FAIL reset: en/buz/busy=%h/%b/%b required 0/0/0", alarm_hourly_en, buzzer, busy);
    end
    nRST = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%b required 0", busy);
    end
  endtask

  task automatic test_auto_chime();
    int cnt = 0, retrig = 0;
    chime_on = 1; hour_decimal = 3; minute_decimal = 1; second_decimal = 0;
    tick();
    minute_decimal = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i == 0) begin
        checks++;
        if ({alarm_hourly_en, buzzer, busy} !== {6'd1, 1'b1, 1'b1}) begin
          errors++;
          $display("FAIL auto_latency: en/buz/busy=%0d/%b/%b required 1/1/1", alarm_hourly_en, buzzer, busy);
        end
      end
      checks++;
      if ({alarm_hourly_en, buzzer, busy} !== m_out()) begin
        errors++;
        $display("FAIL auto_seq: got %h required %h", {alarm_hourly_en, buzzer, busy}, m_out());
      end
      if (busy) cnt++;
    end
    checks++;
    if (cnt !== 24) begin
      errors++;
      $display("FAIL auto_len: busy cycles=%0d required 24", cnt);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy) retrig++;
    end
    checks++;
    if (retrig !== 0) begin
      errors++;
      $display("FAIL auto_retrigger: busy cycles=%0d required 0", retrig);
    end
    minute_decimal = 1;
  endtask

  task automatic test_disabled();
    int cnt = 0, peak = 0;
    hour_decimal = 0; minute_decimal = 0; second_decimal = 0; chime_on = 1;
    for (int i = 0; i < 10; i++) begin tick(); if (busy) cnt++; end
    chime_on = 0; hour_decimal = 5;
    for (int i = 0; i < 10; i++) begin tick(); if (busy) cnt++; end
    checks++;
    if (cnt !== 0) begin
      errors++;
      $display("FAIL hour0_disabled: busy cycles=%0d required 0", cnt);
    end
    test_req = 1;
    for (int i = 0; i < 50; i++) begin
      tick();
      test_req = 0;
      if (busy) cnt++;
      if (alarm_hourly_en > peak) peak = alarm_hourly_en;
      checks++;
      if ({alarm_hourly_en, buzzer, busy} !== m_out()) begin
        errors++;
        $display("FAIL manual_seq: got %h required %h", {alarm_hourly_en, buzzer, busy}, m_out());
      end
    end
    checks++;
    if (cnt !== 40 || peak !== 10) begin
      errors++;
      $display("FAIL manual_len: cycles=%0d peak=%0d required 40/10", cnt, peak);
    end
    minute_decimal = 1;
  endtask

  task automatic test_cancel();
    int cnt = 0;
    chime_on = 0; minute_decimal = 1; hour_decimal = 2;
    test_req = 1;
    for (int i = 0; i < 20 && alarm_hourly_en != 2; i++) begin tick(); test_req = 0; end
    test_req = 0;
    checks++;
    if (alarm_hourly_en !== 6'd2) begin
      errors++;
      $display("FAIL cancel_wait: en=%0d required 2", alarm_hourly_en);
    end
    cancel = 1;
    tick();
    cancel = 0;
    checks++;
    if ({alarm_hourly_en, buzzer, busy} !== 8'h00) begin
      errors++;
      $display("FAIL cancel_mid: en/buz/busy=%0d/%b/%b required 0/0/0", alarm_hourly_en, buzzer, busy);
    end
    cancel = 1; test_req = 1;
    tick();
    cancel = 0; test_req = 0;
    for (int i = 0; i < 5; i++) begin if (busy) cnt++; tick(); end
    checks++;
    if (cnt !== 0) begin
      errors++;
      $display("FAIL cancel_with_req: busy cycles=%0d required 0", cnt);
    end
  endtask

  task automatic test_disable_run();
    int peak = 0;
    hour_decimal = 4; chime_on = 1; minute_decimal = 1; second_decimal = 0;
    tick();
    minute_decimal = 0;
    for (int i = 0; i < 40 && alarm_hourly_en != 5; i++) tick();
    checks++;
    if (alarm_hourly_en !== 6'd5) begin
      errors++;
      $display("FAIL disable_wait: en=%0d required 5", alarm_hourly_en);
    end
    chime_on = 0;
    tick();
    checks++;
    if ({alarm_hourly_en, buzzer, busy} !== 8'h00) begin
      errors++;
      $display("FAIL disable_auto: en/buz/busy=%0d/%b/%b required 0/0/0", alarm_hourly_en, buzzer, busy);
    end
    minute_decimal = 1; chime_on = 1;
    tick();
    test_req = 1;
    for (int i = 0; i < 40 && alarm_hourly_en != 5; i++) begin tick(); test_req = 0; end
    test_req = 0;
    chime_on = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (alarm_hourly_en > peak) peak = alarm_hourly_en;
      checks++;
      if ({alarm_hourly_en, buzzer, busy} !== m_out()) begin
        errors++;
        $display("FAIL disable_manual_seq: got %h required %h", {alarm_hourly_en, buzzer, busy}, m_out());
      end
    end
    checks++;
    if (peak !== 8 || busy !== 1'b0) begin
      errors++;
      $display("FAIL disable_manual: peak=%0d busy=%b required 8/0", peak, busy);
    end
  endtask

  task automatic test_back_to_back();
    int peak = 0;
    chime_on = 0; minute_decimal = 1; hour_decimal = 3;
    test_req = 1;
    tick();
    test_req = 0;
    for (int i = 0; i < 5; i++) tick();
    test_req = 1;
    tick();
    test_req = 0;
    hour_decimal = 4;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (alarm_hourly_en > peak) peak = alarm_hourly_en;
      checks++;
      if ({alarm_hourly_en, buzzer, busy} !== m_out()) begin
        errors++;
        $display("FAIL retrigger_seq: got %h required %h", {alarm_hourly_en, buzzer, busy}, m_out());
      end
    end
    checks++;
    if (peak !== 6) begin
      errors++;
      $display("FAIL hour_change: peak=%0d required 6", peak);
    end
    test_req = 1;
    tick();
    test_req = 0;
    for (int i = 0; i < 5; i++) tick();
    nRST = 0;
    tick();
    checks++;
    if ({alarm_hourly_en, buzzer, busy} !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid: en/buz/busy=%0d/%b/%b required 0/0/0", alarm_hourly_en, buzzer, busy);
    end
    nRST = 1;
    tick();
  endtask

  task automatic test_max();
    int cnt = 0, peak = 0;
    chime_on = 0; minute_decimal = 1; hour_decimal = 23;
    test_req = 1;
    for (int i = 0; i < 200; i++) begin
      tick();
      test_req = 0;
      if (busy) cnt++;
      if (alarm_hourly_en > peak) peak = alarm_hourly_en;
    end
    checks++;
    if (cnt !== 184 || peak !== 46) begin
      errors++;
      $display("FAIL max_count: cycles=%0d peak=%0d required 184/46", cnt, peak);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      hour_decimal   = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(5, 23)) : 6'($urandom_range(0, 4));
      minute_decimal = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 59));
      second_decimal = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 59));
      if ($urandom_range(0, 49) == 0) chime_on = ~chime_on;
      test_req = ($urandom_range(0, 14) == 0);
      cancel   = ($urandom_range(0, 59) == 0);
      nRST     = ($urandom_range(0, 149) != 0);
      tick();
      checks++;
      if ({alarm_hourly_en, buzzer, busy} !== m_out()) begin
        errors++;
        $display("FAIL random[%0d]: got %h required %h", i, {alarm_hourly_en, buzzer, busy}, m_out());
      end
    end
    test_req = 0; cancel = 0; nRST = 1;
  endtask

  initial begin
    test_reset();
    test_auto_chime();
    test_disabled();
    test_cancel();
    test_disable_run();
    test_back_to_back();
    test_max();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
